// File: rtl/iopad_link_ctrl_pkg.sv
// Shared types and constants for the iopad link controller.
package iopad_link_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TURN,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_e;

  localparam logic PAD_DIR_IN  = 1'b1;
  localparam logic PAD_DIR_OUT = 1'b0;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iopad_link_ctrl_bit_timer.sv
// Loadable down-counter. tc is high while the count sits at zero, so a
// load of N-1 makes the owning state last exactly N cycles.
module iopad_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count down to zero and hold there until the next load.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/iopad_link_ctrl.sv
// Half-duplex bit-serial link controller for one bidirectional iopad:
// sends a command frame, turns the bus around, receives the response.
// Optional build macro IOPAD_LINK_CTRL_PARITY_EN adds an even-parity bit
// after the data bits in both directions.
module iopad_link_ctrl
  import iopad_link_ctrl_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int TURN_CYCLES  = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              rx_timeout,
  output logic              busy,
  output logic              pad_dout,
  output logic              pad_zin,
  output logic              pad_dir,
  input  logic              pad_din
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int TMR_W = $clog2(max3(CLKS_PER_BIT, TURN_CYCLES, TIMEOUT) + 1);
`ifdef IOPAD_LINK_CTRL_PARITY_EN
  localparam int LAST_IDX = DATA_W;      // parity rides at index DATA_W
`else
  localparam int LAST_IDX = DATA_W - 1;
`endif
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  rx_data_d;
  logic               drive_d, dout_d, frame_ok;
  logic               rx_valid_d, rx_err_d, rx_timeout_d;
  logic               tmr_load, tmr_tc, to_load, to_tc;
  logic [TMR_W-1:0]   tmr_val;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
  logic               tx_par_q, tx_par_d, rx_par_q, rx_par_d;
`endif

  // Bit period, half-bit and turnaround share one timer; the response
  // timeout has its own so a start-bit glitch does not disturb it.
  iopad_bit_timer #(.W(TMR_W)) u_bit_timer (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .load_val(tmr_val), .tc(tmr_tc)
  );
  iopad_bit_timer #(.W(TMR_W)) u_to_timer (
    .clk(clk), .rst_n(rst_n), .load(to_load), .load_val(TO_LOAD), .tc(to_tc)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  // Next-state, datapath and next registered-output decode.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data;
    drive_d      = !pad_zin;
    dout_d       = pad_dout;
    frame_ok     = 1'b0;
    rx_valid_d   = 1'b0;
    rx_err_d     = 1'b0;
    rx_timeout_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = BIT_LOAD;
    to_load      = 1'b0;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
    tx_par_d     = tx_par_q;
    rx_par_d     = rx_par_q;
`endif
    unique case (state_q)
      IDLE: if (tx_valid) begin
        tx_shift_d = tx_data;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
        tx_par_d   = ^tx_data;
`endif
        state_d    = TX_START;
        drive_d    = 1'b1;
        dout_d     = START_BIT;
        tmr_load   = 1'b1;
      end
      TX_START: if (tmr_tc) begin
        state_d    = TX_DATA;
        bit_idx_d  = '0;
        dout_d     = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tmr_load   = 1'b1;
      end
      TX_DATA: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (bit_idx_q == IDX_W'(LAST_IDX)) begin
          state_d = TX_STOP;
          dout_d  = STOP_BIT;
        end else begin
          bit_idx_d  = bit_idx_q + IDX_W'(1);
          dout_d     = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
          if (bit_idx_q == IDX_W'(DATA_W - 1)) dout_d = tx_par_q;
`endif
        end
      end
      TX_STOP: if (tmr_tc) begin
        state_d  = TURN;
        drive_d  = 1'b0;
        dout_d   = STOP_BIT;
        tmr_load = 1'b1;
        tmr_val  = TURN_LOAD;
      end
      TURN: if (tmr_tc) begin
        state_d = RX_WAIT;
        to_load = 1'b1;
      end
      RX_WAIT: begin
        if (pad_din == START_BIT) begin
          state_d  = RX_START;
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end else if (to_tc) begin
          state_d      = IDLE;
          rx_timeout_d = 1'b1;
        end
      end
      RX_START: if (tmr_tc) begin
        if (pad_din == START_BIT) begin
          state_d   = RX_DATA;
          bit_idx_d = '0;
          tmr_load  = 1'b1;
        end else begin
          state_d = RX_WAIT;   // glitch: timeout keeps running
        end
      end
      RX_DATA: if (tmr_tc) begin
        tmr_load = 1'b1;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
        if (bit_idx_q == IDX_W'(DATA_W)) rx_par_d = pad_din;
        else rx_shift_d = (rx_shift_q >> 1) | (DATA_W'(pad_din) << (DATA_W - 1));
`else
        rx_shift_d = (rx_shift_q >> 1) | (DATA_W'(pad_din) << (DATA_W - 1));
`endif
        if (bit_idx_q == IDX_W'(LAST_IDX)) state_d = RX_STOP;
        else bit_idx_d = bit_idx_q + IDX_W'(1);
      end
      RX_STOP: if (tmr_tc) begin
        state_d  = IDLE;
        frame_ok = (pad_din == STOP_BIT);
`ifdef IOPAD_LINK_CTRL_PARITY_EN
        frame_ok = frame_ok && ((^rx_shift_q) == rx_par_q);
`endif
        if (frame_ok) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          rx_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered pad/host outputs; reset releases the pad at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_timeout <= 1'b0;
      pad_dout   <= 1'b1;
      pad_zin    <= 1'b1;
      pad_dir    <= PAD_DIR_IN;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_err     <= rx_err_d;
      rx_timeout <= rx_timeout_d;
      pad_dout   <= dout_d;
      pad_zin    <= !drive_d;
      pad_dir    <= drive_d ? PAD_DIR_OUT : PAD_DIR_IN;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_iopad_link_ctrl.sv
// Directed bench for iopad_link_ctrl: checks the TX pad waveform cycle by
// cycle, plays the far end, and scoreboards every response pulse.
module tb_iopad_link_ctrl;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int TURN = 2;
  localparam int TMO  = 64;
`ifdef IOPAD_LINK_CTRL_PARITY_EN
  localparam int FB = DW + 3;
`else
  localparam int FB = DW + 2;
`endif

  typedef enum logic [1:0] {EV_VALID, EV_ERR, EV_TIMEOUT} ev_e;
  typedef struct {
    ev_e           kind;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   frames = 0;
  int   f0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_err, rx_timeout, busy;
  logic          pad_dout, pad_zin, pad_dir, pad_din;

  iopad_link_ctrl #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .TURN_CYCLES(TURN), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .rx_timeout(rx_timeout), .busy(busy),
    .pad_dout(pad_dout), .pad_zin(pad_zin), .pad_dir(pad_dir), .pad_din(pad_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FB-1:0] frame_bits(input logic [DW-1:0] d, input logic par,
                                               input logic stop);
`ifdef IOPAD_LINK_CTRL_PARITY_EN
    return {stop, par, d, 1'b0};
`else
    return {stop, d, 1'b0};
`endif
  endfunction

  // Frame-start counter and response scoreboard, sampled on the falling edge.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    ev_e  k;
    if (busy === 1'b1 && busy_prev === 1'b0) frames++;
    busy_prev = busy;
    if (rx_valid === 1'b1 || rx_err === 1'b1 || rx_timeout === 1'b1) begin
      check("pulse_onehot", 32'($onehot({rx_valid, rx_err, rx_timeout})), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {rx_valid, rx_err, rx_timeout}, 0);
      end else begin
        e = exp_q.pop_front();
        k = rx_valid ? EV_VALID : (rx_err ? EV_ERR : EV_TIMEOUT);
        check("pulse_kind", k, e.kind);
        check("pulse_rx_data", rx_data, e.data);
      end
    end
  end

  // Start a frame from IDLE and check the driven window; returns on the first released cycle.
  task automatic send_frame(input logic [DW-1:0] d, input bit hold, input bit chk);
    logic [FB-1:0] bits;
    bits     = frame_bits(d, ^d, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    for (int c = 0; c < FB * CPB; c++) begin
      if (chk) check($sformatf("tx_pad_c%0d", c), {pad_dir, pad_zin, pad_dout},
                     {2'b00, bits[c / CPB]});
      @(negedge clk);
    end
    check("tx_released", {pad_dir, pad_zin, busy}, 3'b111);
  endtask

  // Far end answers TURN cycles after release.
  task automatic respond(input logic [DW-1:0] d, input logic par, input logic stop);
    logic [FB-1:0] bits;
    bits = frame_bits(d, par, stop);
    tick(TURN);
    for (int b = 0; b < FB; b++) begin
      pad_din = bits[b];
      tick(CPB);
    end
    pad_din = 1'b1;
  endtask

  // Bounded wait for the scoreboard to empty, then confirm the block is idle.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    tick(2);
    check({tag, "_idle"}, {busy, tx_ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    pad_din  = 1'b1;
    tick(3);
    check("rst_pad", {pad_dir, pad_zin, pad_dout}, 3'b111);
    check("rst_busy_ready", {busy, tx_ready}, 2'b01);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {rx_valid, rx_err, rx_timeout}, 0);
    rst_n = 1'b1;
    tick(2);

    // Command 0xA5, good response 0x3C.
    send_frame(8'hA5, 1'b0, 1'b1);
    exp_q.push_back('{EV_VALID, 8'h3C});
    respond(8'h3C, ^8'h3C, 1'b1);
    drain("rx_3c");
    check("rx_data_after_3c", rx_data, 8'h3C);

    // No response: timeout exactly TIMEOUT cycles into RX_WAIT.
    send_frame(8'h5A, 1'b0, 1'b1);
    exp_q.push_back('{EV_TIMEOUT, 8'h3C});
    tick(TURN + TMO - 1);
    check("timeout_not_early", rx_timeout, 0);
    tick(1);
    check("timeout_pulse", rx_timeout, 1);
    drain("timeout");

    // Response with stop bit 0.
    send_frame(8'h0F, 1'b0, 1'b0);
    exp_q.push_back('{EV_ERR, 8'h3C});
    respond(8'h99, ^8'h99, 1'b0);
    drain("bad_stop");
    check("rx_data_after_err", rx_data, 8'h3C);

    // One-cycle low glitch in RX_WAIT, then a real response.
    send_frame(8'hC0, 1'b0, 1'b0);
    tick(TURN);
    pad_din = 1'b0;
    tick(1);
    pad_din = 1'b1;
    tick(8);
    check("glitch_no_pulse", {rx_valid, rx_err, rx_timeout, busy}, 4'b0001);
    exp_q.push_back('{EV_VALID, 8'h81});
    respond(8'h81, ^8'h81, 1'b1);
    drain("glitch_then_frame");

    // Reset for one edge in the middle of TX_DATA.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(CPB * 3);
    rst_n = 1'b0;
    tick(1);
    check("midreset_pad", {pad_dir, pad_zin, pad_dout}, 3'b111);
    check("midreset_busy", busy, 0);
    check("midreset_rx_data", rx_data, 0);
    rst_n = 1'b1;
    tick(150);
    drain("midreset_quiet");

    // tx_valid held high throughout: one frame only until IDLE.
    f0 = frames;
    send_frame(8'h33, 1'b1, 1'b1);
    check("hold_single_frame", frames - f0, 1);
    exp_q.push_back('{EV_VALID, 8'hC3});
    respond(8'hC3, ^8'hC3, 1'b1);
    tick(1);
    tx_valid = 1'b0;
    check("hold_next_after_idle", frames - f0, 2);
    exp_q.push_back('{EV_TIMEOUT, 8'hC3});
    drain("hold_second_timeout");

`ifdef IOPAD_LINK_CTRL_PARITY_EN
    // Parity: TX 0x07 carries parity 1; RX 0x01 with parity 0 is an error.
    send_frame(8'h07, 1'b0, 1'b1);
    exp_q.push_back('{EV_ERR, 8'hC3});
    respond(8'h01, 1'b0, 1'b1);
    drain("parity_err");
    check("rx_data_after_parity_err", rx_data, 8'hC3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
